mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx_pkg.sv | 45 ++++
 rtl/mmio_uart_tx_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, FSM encoding, STATUS layout and the bit-period helper.
package mmio_uart_tx_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned BIT_IDX_W = 3;
    localparam int unsigned STAT_CNT_W = 4;

    // Word offsets decoded from i_mem_addr[3:2]
    localparam logic [OFF_W-1:0] UART_TXDATA = 2'd0;
    localparam logic [OFF_W-1:0] UART_STATUS = 2'd1;
    localparam logic [OFF_W-1:0] UART_BAUD   = 2'd2;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_EMPTY = 2;
    localparam int unsigned STAT_OVF   = 3;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_e;

    // STATUS read layout, MSB first
    typedef struct packed {
        logic [DATA_W-BYTE_W-1:0] rsvd;
        logic [STAT_CNT_W-1:0]    count;
        logic                     ovf;
        logic                     empty;
        logic                     full;
        logic                     busy;
    } uart_status_t;

    // Baud counter reload value: P-1, where a divisor of 0 behaves like 1
    function automatic logic [BAUD_W-1:0] bit_reload(input logic [BAUD_W-1:0] div);
        return (div == '0) ? '0 : div - BAUD_W'(1);
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO.
// Ports: i_clk, i_rst_n (async active-low), push/din (write, ignored when full),
//        pop (read, ignored when empty), dout (head, combinational),
//        full, empty, count (occupancy, log2(DEPTH)+1 bits).
module mmio_uart_tx_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BYTE_W-1:0]          din,
    output logic [BYTE_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, entries are only read once written
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data-memory port.
// Ports: i_clk, i_rst_n (async active-low), i_clk_en (global stall),
//        i_sel/i_mem_write/i_mem_addr/i_mem_data (responder side of the store path),
//        o_mem_data (combinational load data), o_tx (serial line, idles high),
//        o_irq (FIFO empty and transmitter idle).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter logic [BAUD_W-1:0] DEFAULT_DIV = 16'd434
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_en,
    input  logic              i_sel,
    input  logic              i_mem_write,
    input  logic [DATA_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_tx,
    output logic              o_irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [OFF_W-1:0]     off;
    logic                 wr_acc;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [BYTE_W-1:0]    head;
    logic [CW-1:0]        count;
    utx_state_e           state;
    logic [BAUD_W-1:0]    baud_div;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BYTE_W-1:0]    shift_reg;
    logic                 ovf;
    logic                 tx_line;
    uart_status_t         status;
    logic                 unused_bits;

    assign unused_bits = ^{i_mem_addr[DATA_W-1:4], i_mem_addr[1:0], i_mem_data[DATA_W-1:BAUD_W]};

    assign off    = i_mem_addr[3:2];
    assign wr_acc = i_clk_en && i_sel && i_mem_write;
    assign push   = wr_acc && (off == UART_TXDATA);
    // Pop when starting a frame from idle or chaining one straight after a stop bit
    assign pop    = i_clk_en && !empty &&
                    ((state == UTX_IDLE) || (state == UTX_STOP && baud_cnt == '0));

    mmio_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .din     (i_mem_data[BYTE_W-1:0]),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Writable registers; full is sampled before any same-cycle pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_div <= DEFAULT_DIV;
            ovf      <= 1'b0;
        end else if (wr_acc) begin
            case (off)
                UART_TXDATA: if (full) ovf <= 1'b1;
                UART_STATUS: if (i_mem_data[STAT_OVF]) ovf <= 1'b0;
                UART_BAUD:   baud_div <= i_mem_data[BAUD_W-1:0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        status       = '0;
        status.busy  = (state != UTX_IDLE);
        status.full  = full;
        status.empty = empty;
        status.ovf   = ovf;
        status.count = STAT_CNT_W'(count);
    end

    // Load data, combinational from address and current state
    always_comb begin
        o_mem_data = '0;
        if (i_sel) begin
            case (off)
                UART_STATUS: o_mem_data = status;
                UART_BAUD:   o_mem_data = DATA_W'(baud_div);
                default:     o_mem_data = '0;
            endcase
        end
    end

    // Line level implied by the current state; o_tx registers it one edge later
    always_comb begin
        tx_line = 1'b1;
        case (state)
            UTX_START: tx_line = 1'b0;
            UTX_DATA:  tx_line = shift_reg[bit_idx];
            default:   tx_line = 1'b1;
        endcase
    end

    // Transmit FSM with baud counter and registered line/irq outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= UTX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            o_tx      <= 1'b1;
            o_irq     <= 1'b1;
        end else if (i_clk_en) begin
            o_tx  <= tx_line;
            o_irq <= (state == UTX_IDLE) && empty;
            case (state)
                UTX_IDLE: begin
                    if (!empty) begin
                        shift_reg <= head;
                        baud_cnt  <= bit_reload(baud_div);
                        state     <= UTX_START;
                    end
                end
                UTX_START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end else begin
                        baud_cnt <= bit_reload(baud_div);
                        bit_idx  <= '0;
                        state    <= UTX_DATA;
                    end
                end
                UTX_DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end else begin
                        baud_cnt <= bit_reload(baud_div);
                        if (bit_idx == BIT_IDX_W'(7)) begin
                            state <= UTX_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
                UTX_STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end else if (!empty) begin
                        shift_reg <= head;
                        baud_cnt  <= bit_reload(baud_div);
                        state     <= UTX_START;
                    end else begin
                        state <= UTX_IDLE;
                    end
                end
                default: state <= UTX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: expected frames are queued at stimulus
// time and a line monitor decodes o_tx and compares frame by frame.
module tb_mmio_uart_tx;

    logic        i_clk       = 1'b0;
    logic        i_rst_n     = 1'b0;
    logic        i_clk_en    = 1'b1;
    logic        i_sel       = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [31:0] i_mem_addr  = '0;
    logic [31:0] i_mem_data  = '0;
    logic [31:0] o_mem_data;
    logic        o_tx;
    logic        o_irq;

    mmio_uart_tx dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clk_en    (i_clk_en),
        .i_sel       (i_sel),
        .i_mem_write (i_mem_write),
        .i_mem_addr  (i_mem_addr),
        .i_mem_data  (i_mem_data),
        .o_mem_data  (o_mem_data),
        .o_tx        (o_tx),
        .o_irq       (o_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       b2b;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   bit_cyc  = 4;
    bit   mon_en   = 1'b1;
    bit   in_frame = 1'b0;

    localparam logic [1:0] OFF_TX = 2'd0;
    localparam logic [1:0] OFF_ST = 2'd1;
    localparam logic [1:0] OFF_BD = 2'd2;
    localparam logic [1:0] OFF_RS = 2'd3;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One-cycle store, launched at a falling edge
    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        i_sel       = 1'b1;
        i_mem_write = 1'b1;
        i_mem_addr  = {28'h0, off, 2'b00};
        i_mem_data  = d;
        @(negedge i_clk);
        i_sel       = 1'b0;
        i_mem_write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] off, input logic [31:0] exp);
        i_sel       = 1'b1;
        i_mem_write = 1'b0;
        i_mem_addr  = {28'h0, off, 2'b00};
        #1;
        check32(name, o_mem_data, exp);
        i_sel = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || in_frame) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL drain: %0d frames still pending after %0d cycles", sb_q.size(), limit);
        end
    endtask

    // Line monitor: decode start/data/stop, each bit must hold bit_cyc samples
    initial begin : monitor
        logic       prev;
        logic       samp;
        logic [9:0] vals;
        bit         stable;
        int         idle;
        int         bc;
        exp_t       e;
        prev = 1'b1;
        idle = 0;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n && prev === 1'b1 && o_tx === 1'b0) begin
                in_frame = 1'b1;
                bc       = bit_cyc;
                stable   = 1'b1;
                vals     = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < bc; c++) begin
                        if (b != 0 || c != 0) @(negedge i_clk);
                        samp = o_tx;
                        if (c == 0) vals[b] = samp;
                        else if (samp !== vals[b]) stable = 1'b0;
                    end
                end
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame: unexpected frame data 0x%02h", vals[8:1]);
                end else begin
                    e = sb_q.pop_front();
                    if ({vals[9], stable, vals[0], vals[8:1]} !== {1'b1, 1'b1, 1'b0, e.data}) begin
                        bad++;
                        $display("FAIL frame: got stop=%b stable=%b start=%b data=0x%02h expected stop=1 stable=1 start=0 data=0x%02h",
                                 vals[9], stable, vals[0], vals[8:1], e.data);
                    end
                    if (e.b2b) begin
                        total++;
                        if (idle != 0) begin
                            bad++;
                            $display("FAIL frame_gap: got %0d idle cycles before 0x%02h expected 0", idle, e.data);
                        end
                    end
                end
                prev     = vals[9];
                idle     = 0;
                in_frame = 1'b0;
            end else begin
                if (o_tx === 1'b1) idle++;
                prev = o_tx;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;

        // Reset state
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        rd_check("reset_status", OFF_ST, 32'h0000_0004);
        rd_check("reset_baud",   OFF_BD, 32'd434);
        check32("reset_tx",  32'(o_tx),  32'd1);
        check32("reset_irq", 32'(o_irq), 32'd1);

        // Single frame, 4 cycles per bit
        wr(OFF_BD, 32'd4);
        rd_check("baud_rw", OFF_BD, 32'd4);
        bit_cyc = 4;
        sb_q.push_back('{8'hA5, 1'b0});
        wr(OFF_TX, 32'h0000_00A5);
        repeat (3) @(negedge i_clk);
        check32("irq_during_frame", 32'(o_irq), 32'd0);
        n = 0;
        while (o_irq !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check32("irq_after_frame", 32'(o_irq), 32'd1);
        wait_drain(50);
        rd_check("status_after_frame", OFF_ST, 32'h0000_0004);

        // FIFO fill and overflow
        wr(OFF_BD, 32'd100);
        bit_cyc = 100;
        for (int i = 0; i < 9; i++) sb_q.push_back('{8'(i), (i != 0)});
        for (int i = 0; i < 10; i++) wr(OFF_TX, 32'(i));
        rd_check("status_full_ovf", OFF_ST, 32'h0000_008B);
        wr(OFF_ST, 32'hFFFF_FFF7);
        rd_check("ovf_kept", OFF_ST, 32'h0000_008B);
        wr(OFF_ST, 32'h0000_0008);
        rd_check("ovf_cleared", OFF_ST, 32'h0000_0083);
        wait_drain(12000);
        rd_check("status_drained", OFF_ST, 32'h0000_0004);

        // Back-to-back frames
        wr(OFF_BD, 32'd2);
        bit_cyc = 2;
        sb_q.push_back('{8'h55, 1'b0});
        sb_q.push_back('{8'h0F, 1'b1});
        wr(OFF_TX, 32'h0000_0055);
        wr(OFF_TX, 32'h0000_000F);
        wait_drain(200);

        // Clock enable and divide-by-zero
        wr(OFF_BD, 32'd0);
        i_clk_en = 1'b0;
        wr(OFF_TX, 32'h0000_0077);
        i_clk_en = 1'b1;
        rd_check("clk_en_low_no_push", OFF_ST, 32'h0000_0004);
        rd_check("baud_zero", OFF_BD, 32'd0);
        bit_cyc = 2;
        sb_q.push_back('{8'h3C, 1'b0});
        wr(OFF_TX, 32'h0000_003C);
        for (int k = 0; k < 60; k++) begin
            i_clk_en = ~i_clk_en;
            @(negedge i_clk);
        end
        i_clk_en = 1'b1;
        wait_drain(100);

        // Deselected accesses
        i_sel       = 1'b0;
        i_mem_write = 1'b1;
        i_mem_addr  = 32'h0;
        i_mem_data  = 32'h11;
        @(negedge i_clk);
        i_mem_write = 1'b0;
        i_mem_addr  = 32'h4;
        #1;
        check32("nosel_read", o_mem_data, 32'h0);
        rd_check("nosel_no_push", OFF_ST, 32'h0000_0004);
        rd_check("reserved_read", OFF_RS, 32'h0);
        rd_check("txdata_read",   OFF_TX, 32'h0);

        // Reset during data bit 3 of 0x00
        wr(OFF_BD, 32'd4);
        mon_en = 1'b0;
        wr(OFF_TX, 32'h0000_0000);
        repeat (19) @(negedge i_clk);
        check32("pre_reset_bit3", 32'(o_tx), 32'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check32("async_reset_tx", 32'(o_tx), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        rd_check("post_reset_status", OFF_ST, 32'h0000_0004);
        rd_check("post_reset_baud",   OFF_BD, 32'd434);
        check32("post_reset_tx", 32'(o_tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
